// File: rtl/ripple_cla_seq_pkg.sv
// ripple_cla_pkg: shared types and elaboration helpers for ripple_cla_seq.
//   state_t    : FSM state encoding (IDLE, CALC, DONE).
//   nslice()   : number of CLA slices needed to cover WIDTH bits.
//   idx_width(): width of the slice index counter (clog2, at least 1 bit).
package ripple_cla_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nslice(input int width, input int slice);
    return width / slice;
  endfunction

  // A single-slice build still needs a 1-bit index so the vector is legal.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ripple_cla_seq_cla_slice.sv
// cla_slice: purely combinational SLICE-bit carry-lookahead adder.
// Ports:
//   a, b   [SLICE-1:0] : slice operands
//   cin                : carry into bit 0
//   sum    [SLICE-1:0] : slice sum
//   cout               : carry out of the top bit
//   c_msb              : carry into the top bit (signed-overflow detection)
module cla_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE-1:0] g;
  logic [SLICE-1:0] p;
  logic [SLICE:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is the flat lookahead sum-of-products:
  //   c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
  // so no carry depends on another carry inside the slice.
  always_comb begin
    logic acc;
    logic pp;
    c    = '0;
    acc  = 1'b0;
    pp   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      acc      = acc | (pp & cin);
      c[i + 1] = acc;
    end
  end

  assign sum   = p ^ c[SLICE-1:0];
  assign cout  = c[SLICE];
  assign c_msb = c[SLICE-1];

endmodule

// File: rtl/ripple_cla_seq.sv
// ripple_cla_seq: multi-cycle WIDTH-bit add/subtract. One SLICE-bit CLA slice
// is evaluated per clock; the carry ripples between slices through carry_q.
// Optional macro RIPPLE_CLA_SEQ_ZFLAG_EN adds the 'zero' result flag.
// Ports:
//   clk, rst_n      : clock (rising edge), async active-low reset
//   en              : level request; accepted in IDLE or DONE, dropping it in
//                     CALC aborts the operation
//   sub             : 0 = A+B+c_in, 1 = A-B-c_in (c_in is borrow-in)
//   A, B, c_in      : operands, sampled on accept
//   Output          : result of last completed op
//   c_out, ovf      : raw carry out of MSB / signed overflow of last op
//   ready           : one-cycle pulse (DONE) when results are new
//   busy            : high while in CALC
//   dbg_state       : current FSM state
//   zero            : (macro only) result of last completed op was all zeros
// Handshake: en is a level, not a pulse. An op is accepted on any edge where
// en=1 and the FSM is in IDLE or DONE; results are valid and new exactly in
// the cycle where ready=1, and are held until the next completion.
module ripple_cla_seq
  import ripple_cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             c_in,
  output logic [WIDTH-1:0] Output,
  output logic             c_out,
  output logic             ovf,
  output logic             ready,
  output logic             busy,
`ifdef RIPPLE_CLA_SEQ_ZFLAG_EN
  output logic             zero,
`endif
  output state_t           dbg_state
);

  // WIDTH must be a multiple of SLICE.
  localparam int             NSLICE   = nslice(WIDTH, SLICE);
  localparam int             IW       = idx_width(NSLICE);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NSLICE - 1);

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bx_q, bx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;
`ifdef RIPPLE_CLA_SEQ_ZFLAG_EN
  logic             zero_q, zero_d;
`endif

  int               base;
  logic [SLICE-1:0] sl_a, sl_b, sl_sum;
  logic             sl_cout, sl_cmsb;

  assign base = int'(idx_q) * SLICE;
  assign sl_a = a_q[base +: SLICE];
  assign sl_b = bx_q[base +: SLICE];

  cla_slice #(.SLICE(SLICE)) u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout),
    .c_msb(sl_cmsb)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    bx_d    = bx_q;
    carry_d = carry_q;
    part_d  = part_q;
    out_d   = out_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
`ifdef RIPPLE_CLA_SEQ_ZFLAG_EN
    zero_d  = zero_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (en) begin
          // Subtraction is A + ~B + ~borrow, so invert B and the carry-in once here.
          state_d = CALC;
          a_d     = A;
          bx_d    = sub ? ~B : B;
          carry_d = sub ^ c_in;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        if (!en) begin
          // Abort: partial result is dropped, held outputs stay untouched.
          state_d = IDLE;
        end else begin
          part_d[base +: SLICE] = sl_sum;
          carry_d = sl_cout;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            out_d   = part_d;
            c_out_d = sl_cout;
            ovf_d   = sl_cmsb ^ sl_cout;
`ifdef RIPPLE_CLA_SEQ_ZFLAG_EN
            zero_d  = (part_d == '0);
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      bx_q    <= '0;
      carry_q <= 1'b0;
      part_q  <= '0;
      out_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef RIPPLE_CLA_SEQ_ZFLAG_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      carry_q <= carry_d;
      part_q  <= part_d;
      out_q   <= out_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
`ifdef RIPPLE_CLA_SEQ_ZFLAG_EN
      zero_q  <= zero_d;
`endif
    end
  end

  assign Output    = out_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;
  assign ready     = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign dbg_state = state_q;
`ifdef RIPPLE_CLA_SEQ_ZFLAG_EN
  assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_ripple_cla_seq.sv
// tb_ripple_cla_seq: self-checking bench for ripple_cla_seq (WIDTH=16, SLICE=4).
// Expected results come from integer arithmetic on the operands.
module tb_ripple_cla_seq;
  import ripple_cla_pkg::*;

  localparam int W   = 16;
  localparam int LAT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         en, sub, c_in;
  logic [W-1:0] A, B;
  logic [W-1:0] out_w;
  logic         c_out, ovf, ready, busy;
  state_t       dbg_state;
`ifdef RIPPLE_CLA_SEQ_ZFLAG_EN
  logic         zero;
`endif

  ripple_cla_seq #(.WIDTH(W), .SLICE(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sub      (sub),
    .A        (A),
    .B        (B),
    .c_in     (c_in),
    .Output   (out_w),
    .c_out    (c_out),
    .ovf      (ovf),
    .ready    (ready),
    .busy     (busy),
`ifdef RIPPLE_CLA_SEQ_ZFLAG_EN
    .zero     (zero),
`endif
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_flags_q[$];   // {ovf, c_out}
  logic [W-1:0] last_out;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: exact integer add/subtract, signed range test for overflow.
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic ci, input logic sb);
    longint ua, ub, r, sa, sbv, t, lim;
    logic   co, ov;
    logic [W-1:0] res;
    ua  = longint'(a);
    ub  = longint'(b);
    lim = longint'(1) << (W - 1);
    sa  = a[W-1] ? ua - (longint'(1) << W) : ua;
    sbv = b[W-1] ? ub - (longint'(1) << W) : ub;
    if (!sb) begin
      r  = ua + ub + longint'(ci);
      co = (r >= (longint'(1) << W));
      t  = sa + sbv + longint'(ci);
    end else begin
      r  = ua - ub - longint'(ci);
      co = (r >= 0);           // carry out 1 means no borrow
      t  = sa - sbv - longint'(ci);
    end
    res = r[W-1:0];
    ov  = (t >= lim) || (t < -lim);
    return {ov, co, res};
  endfunction

  // Wait for ready with a cycle bound; returns edges since accept.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (cnt < 20) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      if (cnt == 2) begin
        check("busy_mid", busy, 1'b1);
        check("out_hold_mid", out_w, last_out);
      end
      if (ready) break;
    end
    check("ready_seen", ready, 1'b1);
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; leaves the bench just after a falling edge.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sb, input bit hold_en);
    logic [W+1:0] r;
    logic [W-1:0] e;
    logic [1:0]   f;
    int           cnt;
    r = ref_model(a, b, ci, sb);
    exp_q.push_back(r[W-1:0]);
    exp_flags_q.push_back(r[W+1:W]);
    en = 1'b1; A = a; B = b; c_in = ci; sub = sb;
    @(posedge clk);
    #1;
    // Operand changes after accept must not matter.
    A = W'($urandom); B = W'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
    wait_ready(cnt);
    check("latency", cnt, LAT);
    e = exp_q.pop_front();
    f = exp_flags_q.pop_front();
    check("result", out_w, e);
    check("c_out", c_out, f[0]);
    check("ovf", ovf, f[1]);
    check("busy_done", busy, 1'b0);
`ifdef RIPPLE_CLA_SEQ_ZFLAG_EN
    check("zero", zero, (e == '0));
`endif
    last_out = e;
    if (!hold_en) begin
      en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("ready_one_cycle", ready, 1'b0);
      check("state_idle", 32'(dbg_state), 32'(IDLE));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit saw_ready;
    rst_n = 1'b0; en = 1'b0; sub = 1'b0; c_in = 1'b0; A = '0; B = '0;
    last_out = '0;
    repeat (2) @(negedge clk);
    check("rst_out", out_w, 0);
    check("rst_c_out", c_out, 0);
    check("rst_ovf", ovf, 0);
    check("rst_ready", ready, 0);
    check("rst_busy", busy, 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
`ifdef RIPPLE_CLA_SEQ_ZFLAG_EN
    check("rst_zero", zero, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back: en held high, results every LAT+1 cycles.
    run_op(16'd127, 16'd127, 1'b0, 1'b0, 1'b1);
    run_op(16'd127, 16'd127, 1'b0, 1'b0, 1'b1);
    run_op(16'd127, 16'd127, 1'b0, 1'b0, 1'b0);

    // Abort after two CALC cycles: no ready, outputs hold 0x00FE.
    en = 1'b1; A = 16'h1111; B = 16'h2222; c_in = 1'b0; sub = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    check("abort_busy", busy, 1'b0);
    check("abort_out", out_w, 16'h00FE);
    saw_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw_ready = saw_ready | ready;
    end
    check("abort_no_ready", saw_ready, 1'b0);
    check("abort_out_hold", out_w, 16'h00FE);

    // Directed boundary cases.
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0);
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0);

    // Async reset in the middle of a cycle during CALC.
    en = 1'b1; A = 16'h1234; B = 16'h4321; c_in = 1'b0; sub = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out", out_w, 0);
    check("arst_c_out", c_out, 0);
    check("arst_ovf", ovf, 0);
    check("arst_busy", busy, 0);
    check("arst_ready", ready, 0);
    en = 1'b0;
    last_out = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(16'd1, 16'd1, 1'b0, 1'b0, 1'b0);

    // Randomized operations, some back-to-back.
    for (int i = 0; i < 40; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), (i % 3 == 1) && (i != 39));
    end

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/ripple_cla_seq.md
Name: ripple_cla_seq

Overview:
- Parametrised, multi-cycle successor to the 16-bit ripple-of-CLA adder.
- Computes a WIDTH-bit add or subtract one SLICE-bit carry-lookahead slice per clock, rippling the carry through a register between slices.
- Adds a subtract mode, signed-overflow detection, abort on en deassertion, and back-to-back operation.
- Sits in the datapath as the ALU adder, trading latency for area and timing.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE.
- SLICE, 4, bits resolved per cycle by one CLA slice; NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  level request; operation accepted when high in IDLE or DONE.
- sub  input  1  0 = A+B+c_in; 1 = A-B-c_in (c_in acts as borrow-in).
- A  input  WIDTH  operand A, sampled on accept.
- B  input  WIDTH  operand B, sampled on accept.
- c_in  input  1  carry/borrow in, sampled on accept.
- Output  output  WIDTH  result; holds last completed value.
- c_out  output  1  raw carry out of MSB (for sub, 1 = no borrow).
- ovf  output  1  signed overflow of last completed op.
- ready  output  1  high for exactly one cycle (DONE) when Output/c_out/ovf are new.
- busy  output  1  high in CALC.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; Output=0, c_out=0, ovf=0, ready=0, busy=0; slice index=0; internal operand regs=0.
- States:
  - IDLE: en=1 -> CALC.
  - CALC: stays for NSLICE cycles, then -> DONE; en=0 at any CALC edge -> IDLE (abort).
  - DONE: en=1 -> CALC (new op accepted); else -> IDLE.
- Accept edge:
  - Latch A and Bx = sub ? ~B : B.
  - Carry register = sub ? ~c_in : c_in.
  - Slice index = 0.
- Each CALC cycle:
  - cla_slice adds slice i of A and Bx plus the carry register.
  - Sum bits are written to slice i of a partial-result register; carry register <= slice carry out; i increments.
  - On the last slice, also capture carry into MSB for ovf.
- Transition to DONE:
  - Output <= full partial result; c_out <= final carry.
  - ovf <= carry into MSB XOR carry out of MSB.
  - Output, c_out and ovf update together, and only here.
- Latency: accept at edge k; ready=1 during the cycle following edge k+NSLICE. With defaults, ready is high 4 edges after accept.
- Throughput: en held high gives one result every NSLICE+1 cycles, with no idle cycle between operations.
- Abort (en=0 during CALC):
  - Partial result is discarded; Output, c_out and ovf retain the prior completed values.
  - ready does not pulse.
- Operand changes on A, B, c_in or sub after accept have no effect until the next accept.
- Reset mid-operation: returns immediately to reset values; no ready pulse.
- SLICE==WIDTH is legal: NSLICE=1, giving a 2-cycle accept-to-ready latency.

Optional Feature:
- RIPPLE_CLA_SEQ_ZFLAG_EN defined:
  - Adds output port zero (1 bit), reset 0.
  - zero updates on DONE entry with the other outputs: 1 iff the result is all zeros.
  - zero is held and unaffected by abort.
- Undefined: the port does not exist and no zero-detect logic is built.

Decomposition:
- Package ripple_cla_pkg:
  - State enum {IDLE, CALC, DONE}.
  - Function nslice(WIDTH, SLICE).
  - Index-width localparam helper (clog2 of NSLICE, minimum 1).
- Sub-module cla_slice:
  - Parametrised by SLICE; purely combinational.
  - Generate/propagate lookahead.
  - Inputs: a, b, cin. Outputs: sum, cout, c_msb (carry into the top bit, used for ovf).
- Top: FSM, slice counter, operand/partial/result registers, slice mux.

Test Plan (WIDTH=16, SLICE=4):
- A=127, B=127, c_in=0, sub=0, en high -> ready pulses 4 edges after accept; Output=0x00FE, c_out=0, ovf=0; en held high -> same result repeats every 5 cycles.
- A=0xFFFF, B=0x0001, sub=0 -> Output=0x0000, c_out=1, ovf=0; with ZFLAG_EN, zero=1.
- A=0x7FFF, B=0x0001, sub=0 -> Output=0x8000, c_out=0, ovf=1.
- A=0x0005, B=0x0007, sub=1, c_in=0 -> Output=0xFFFE, c_out=0 (borrow), ovf=0; then A=0x8000, B=0x0001, sub=1 -> Output=0x7FFF, c_out=1, ovf=1.
- After a completed op giving 0x00FE, start 0x1111+0x2222 and drop en after 2 CALC cycles -> no ready, state IDLE, Output stays 0x00FE.
- Assert rst_n=0 asynchronously mid-CALC (between edges) -> all outputs 0 immediately; after release and en=1 with 1+1 -> Output=0x0002 with normal 4-edge latency.
